// File: rtl/gpu_pkg.sv
// Shared GPU descriptor definitions: copier FSM encoding, default descriptor
// layout and small width helpers.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } copier_state_e;

  localparam int GPU_WORDS_PER_RECT = 6;
  localparam int GPU_FLAGS_WORD     = 0;

  // The enable flag lives in the MSB of the flags word.
  function automatic int gpu_enable_bit(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// Rect/word counters and the descriptor read address (BASE + rect*WPR + word,
// wrapping modulo 2^ADDR_WIDTH). The address register only moves on a counter update.
module rect_addr_gen
  import gpu_pkg::*;
#(
  parameter int                    RECT_COUNT     = 64,
  parameter int                    WORDS_PER_RECT = GPU_WORDS_PER_RECT,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WORD_W         = clog2_min1(WORDS_PER_RECT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  adv_word_i,
  input  logic                  adv_rect_i,
  output logic [WORD_W-1:0]     word_o,
  output logic                  last_word_o,
  output logic                  last_rect_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int RECT_W = clog2_min1(RECT_COUNT);

  logic [RECT_W-1:0]     rect_q, rect_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  upd;

  always_comb begin
    rect_d = rect_q;
    word_d = word_q;
    if (clr_i) begin
      rect_d = '0;
      word_d = '0;
    end else if (adv_rect_i) begin
      rect_d = rect_q + 1'b1;
      word_d = '0;
    end else if (adv_word_i) begin
      word_d = word_q + 1'b1;
    end
  end

  // Truncating casts give the silent wrap at the top of the address space.
  assign addr_d = BASE_ADDR
                + ADDR_WIDTH'(32'(rect_d) * 32'(WORDS_PER_RECT))
                + ADDR_WIDTH'(32'(word_d));
  assign upd    = clr_i | adv_rect_i | adv_word_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rect_q <= '0;
      word_q <= '0;
      addr_q <= '0;
    end else begin
      rect_q <= rect_d;
      word_q <= word_d;
      if (upd) addr_q <= addr_d;
    end
  end

  assign word_o      = word_q;
  assign last_word_o = (word_q == WORD_W'(WORDS_PER_RECT - 1));
  assign last_rect_o = (rect_q == RECT_W'(RECT_COUNT - 1));
  assign addr_o      = addr_q;

endmodule

// File: rtl/rect_list_copier.sv
// Walks a frame's rectangle descriptor list in data memory and streams each
// enabled descriptor to the GPU over a valid/ready word interface.
module rect_list_copier
  import gpu_pkg::*;
#(
  parameter int                    RECT_COUNT     = 64,
  parameter int                    WORDS_PER_RECT = GPU_WORDS_PER_RECT,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter bit                    SKIP_DISABLED  = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   copy_start,
  input  logic                                   copy_abort,
  output logic [ADDR_WIDTH-1:0]                  mem_din_addr,
  input  logic [DATA_WIDTH-1:0]                  mem_din,
  output logic [DATA_WIDTH-1:0]                  mem_dout,
  output logic                                   gpu_valid,
  input  logic                                   gpu_ready,
  output logic [clog2_min1(WORDS_PER_RECT)-1:0]  gpu_word_idx,
  output logic                                   gpu_last,
  output logic                                   gpu_reset,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(RECT_COUNT+1)-1:0]        rects_sent
);

  localparam int EN_BIT = gpu_enable_bit(DATA_WIDTH);
  localparam int WORD_W = clog2_min1(WORDS_PER_RECT);
  localparam int CNT_W  = $clog2(RECT_COUNT + 1);

  copier_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic                  clr, adv_word, adv_rect;
  logic [WORD_W-1:0]     word;
  logic                  last_word, last_rect;
  logic                  xfer;

  rect_addr_gen #(
    .RECT_COUNT     (RECT_COUNT),
    .WORDS_PER_RECT (WORDS_PER_RECT),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BASE_ADDR      (BASE_ADDR),
    .WORD_W         (WORD_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .adv_word_i  (adv_word),
    .adv_rect_i  (adv_rect),
    .word_o      (word),
    .last_word_o (last_word),
    .last_rect_o (last_rect),
    .addr_o      (mem_din_addr)
  );

  assign xfer = gpu_valid && gpu_ready;

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    sent_d   = sent_q;
    clr      = 1'b0;
    adv_word = 1'b0;
    adv_rect = 1'b0;
    if (copy_abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (copy_start) begin
            clr     = 1'b1;
            sent_d  = '0;
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: state_d = ST_ISSUE;
        ST_ISSUE: state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          dout_d = mem_din;
          if (SKIP_DISABLED && word == '0 && !mem_din[EN_BIT]) begin
            if (last_rect) begin
              state_d = ST_DONE;
            end else begin
              adv_rect = 1'b1;
              state_d  = ST_ISSUE;
            end
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (!last_word) begin
              adv_word = 1'b1;
              state_d  = ST_ISSUE;
            end else if (!last_rect) begin
              adv_rect = 1'b1;
              sent_d   = sent_q + 1'b1;
              state_d  = ST_ISSUE;
            end else begin
              sent_d  = sent_q + 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sent_q  <= sent_d;
    end
  end

  // Valid drops with abort so the GPU never sees a handshake the copier discards.
  assign gpu_valid    = (state_q == ST_SEND) && !copy_abort;
  assign gpu_last     = (state_q == ST_SEND) && last_word;
  assign gpu_word_idx = word;
  assign gpu_reset    = (state_q == ST_CLEAR);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign mem_dout     = dout_q;
  assign rects_sent   = sent_q;

endmodule

// File: tb/tb_rect_list_copier.sv
// Directed bench: two copier instances (2x3 list at 0x0100, 1x3 list wrapping at 0xFFFE).
module tb_rect_list_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: RECT_COUNT=2, WPR=3, BASE=0x0100
  logic        reset_a, start_a, abort_a, ready_a;
  logic [15:0] addr_a, din_a, dout_a;
  logic        valid_a, last_a, greset_a, busy_a, done_a;
  logic [1:0]  idx_a, sent_a;
  logic [15:0] mem_a [0:7];

  // Instance B: RECT_COUNT=1, WPR=3, BASE=0xFFFE
  logic        reset_b, start_b, abort_b, ready_b;
  logic [15:0] addr_b, din_b, dout_b;
  logic        valid_b, last_b, greset_b, busy_b, done_b;
  logic [1:0]  idx_b;
  logic [0:0]  sent_b;

  logic [15:0] exp_d [6] = '{16'h8001, 16'h0002, 16'h0003, 16'h8004, 16'h0005, 16'h0006};

  rect_list_copier #(.RECT_COUNT(2), .WORDS_PER_RECT(3), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                     .BASE_ADDR(16'h0100), .SKIP_DISABLED(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .copy_start(start_a), .copy_abort(abort_a),
    .mem_din_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a),
    .gpu_valid(valid_a), .gpu_ready(ready_a), .gpu_word_idx(idx_a), .gpu_last(last_a),
    .gpu_reset(greset_a), .busy(busy_a), .done(done_a), .rects_sent(sent_a));

  rect_list_copier #(.RECT_COUNT(1), .WORDS_PER_RECT(3), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                     .BASE_ADDR(16'hFFFE), .SKIP_DISABLED(1'b1)) dut_b (
    .clk(clk), .reset(reset_b), .copy_start(start_b), .copy_abort(abort_b),
    .mem_din_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b),
    .gpu_valid(valid_b), .gpu_ready(ready_b), .gpu_word_idx(idx_b), .gpu_last(last_b),
    .gpu_reset(greset_b), .busy(busy_b), .done(done_b), .rects_sent(sent_b));

  // Synchronous-read memories, one cycle latency.
  always @(posedge clk) begin
    din_a <= (addr_a >= 16'h0100 && addr_a < 16'h0108) ? mem_a[addr_a[2:0]] : 16'hDEAD;
    case (addr_b)
      16'hFFFE: din_b <= 16'h8AAA;
      16'hFFFF: din_b <= 16'h0BBB;
      16'h0000: din_b <= 16'h0CCC;
      default:  din_b <= 16'hDEAD;
    endcase
  end

  logic [15:0] xd_a[$], alog_a[$], xd_b[$], alog_b[$];
  logic [1:0]  xi_a[$];
  logic        xl_a[$], xl_b[$];
  int nreset_a, ndone_a, nbusy_a, nover;

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      xd_a.push_back(dout_a); xi_a.push_back(idx_a); xl_a.push_back(last_a);
    end
    if (greset_a) nreset_a++;
    if (done_a) ndone_a++;
    if (busy_a) begin
      nbusy_a++;
      if (alog_a.size() == 0 || alog_a[$] != addr_a) alog_a.push_back(addr_a);
    end
    if (valid_b && ready_b) begin
      xd_b.push_back(dout_b); xl_b.push_back(last_b);
    end
    if (busy_b && (alog_b.size() == 0 || alog_b[$] != addr_b)) alog_b.push_back(addr_b);
    if (int'(valid_a) + int'(greset_a) + int'(done_a) > 1) nover++;
    if (int'(valid_b) + int'(greset_b) + int'(done_b) > 1) nover++;
  end

  task automatic clear_mon();
    xd_a.delete(); xi_a.delete(); xl_a.delete(); alog_a.delete();
    xd_b.delete(); xl_b.delete(); alog_b.delete();
    nreset_a = 0; ndone_a = 0; nbusy_a = 0;
  endtask

  task automatic pulse_start(input bit sel_b);
    @(posedge clk); #1;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel_b ? done_b : done_a) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_done_timeout got=no_done exp=done_within_300", name);
    end
  endtask

  task automatic check_full_stream(input string name);
    checks++;
    if (xd_a.size() !== 6) begin
      failures++; $display("FAIL %s_xfer_count got=%0d exp=6", name, xd_a.size());
    end
    for (int i = 0; i < xd_a.size() && i < 6; i++) begin
      checks++;
      if (xd_a[i] !== exp_d[i] || xi_a[i] !== 2'(i % 3) || xl_a[i] !== (i % 3 == 2)) begin
        failures++;
        $display("FAIL %s_word%0d got=%h/idx%0d/last%0b exp=%h/idx%0d/last%0b", name, i,
                 xd_a[i], xi_a[i], xl_a[i], exp_d[i], i % 3, (i % 3 == 2));
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy_a, valid_a, done_a, greset_a, addr_a, dout_a, sent_a} !== '0) begin
      failures++;
      $display("FAIL reset_a_outputs got=busy%0b valid%0b done%0b greset%0b addr%h dout%h sent%0d exp=all_zero",
               busy_a, valid_a, done_a, greset_a, addr_a, dout_a, sent_a);
    end
    checks++;
    if ({busy_b, valid_b, done_b, greset_b, addr_b, dout_b, sent_b} !== '0) begin
      failures++; $display("FAIL reset_b_outputs got=busy%0b addr%h exp=all_zero", busy_b, addr_b);
    end
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || addr_a !== 16'h0000) begin
      failures++; $display("FAIL post_reset_idle got=busy%0b addr%h exp=busy0 addr0000", busy_a, addr_a);
    end
  endtask

  task automatic test_full_list();
    clear_mon(); ready_a = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, "full");
    check_full_stream("full");
    checks++;
    if (nreset_a !== 1 || ndone_a !== 1 || sent_a !== 2'd2) begin
      failures++; $display("FAIL full_pulses got=greset%0d done%0d sent%0d exp=1/1/2", nreset_a, ndone_a, sent_a);
    end
    checks++;
    if (nbusy_a !== 20) begin
      failures++; $display("FAIL full_busy_cycles got=%0d exp=20", nbusy_a);
    end
    checks++;
    if (alog_a.size() !== 6) begin
      failures++; $display("FAIL full_addr_count got=%0d exp=6", alog_a.size());
    end
    for (int i = 0; i < alog_a.size() && i < 6; i++) begin
      checks++;
      if (alog_a[i] !== 16'h0100 + 16'(i)) begin
        failures++; $display("FAIL full_addr%0d got=%h exp=%h", i, alog_a[i], 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_skip();
    bit saw104 = 1'b0;
    mem_a[3] = 16'h0004;
    clear_mon(); ready_a = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, "skip");
    checks++;
    if (xd_a.size() !== 3 || xd_a[0] !== 16'h8001 || xd_a[1] !== 16'h0002 || xd_a[2] !== 16'h0003) begin
      failures++; $display("FAIL skip_stream got=count%0d exp=3 words 8001,0002,0003", xd_a.size());
    end
    foreach (alog_a[i]) if (alog_a[i] == 16'h0104) saw104 = 1'b1;
    checks++;
    if (saw104 !== 1'b0 || alog_a.size() !== 4) begin
      failures++; $display("FAIL skip_addr got=saw104_%0b count%0d exp=saw104_0 count4", saw104, alog_a.size());
    end
    checks++;
    if (sent_a !== 2'd1 || ndone_a !== 1 || nbusy_a !== 13) begin
      failures++; $display("FAIL skip_status got=sent%0d done%0d busy%0d exp=1/1/13", sent_a, ndone_a, nbusy_a);
    end
    mem_a[3] = 16'h8004;
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    clear_mon(); ready_a = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid_a && idx_a == 2'd1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL bp_reach_word2 got=not_found exp=valid_idx1");
    end
    ready_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_a !== 1'b1 || dout_a !== 16'h0002 || idx_a !== 2'd1 || addr_a !== 16'h0101) begin
        failures++;
        $display("FAIL bp_hold_cycle%0d got=valid%0b dout%h idx%0d addr%h exp=valid1 dout0002 idx1 addr0101",
                 c, valid_a, dout_a, idx_a, addr_a);
      end
    end
    ready_a = 1'b1;
    wait_done(1'b0, "bp");
    check_full_stream("bp");
    checks++;
    if (nbusy_a !== 25) begin
      failures++; $display("FAIL bp_busy_cycles got=%0d exp=25", nbusy_a);
    end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    clear_mon(); ready_a = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid_a && idx_a == 2'd1 && xd_a.size() == 4) begin found = 1'b1; break; end
    end
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checks++;
    if (!found || busy_a !== 1'b0 || sent_a !== 2'd1 || xd_a.size() !== 4) begin
      failures++;
      $display("FAIL abort_state got=found%0b busy%0b sent%0d xfers%0d exp=found1 busy0 sent1 xfers4",
               found, busy_a, sent_a, xd_a.size());
    end
    repeat (5) @(posedge clk); #1;
    checks++;
    if (ndone_a !== 0 || busy_a !== 1'b0 || sent_a !== 2'd1) begin
      failures++; $display("FAIL abort_quiet got=done%0d busy%0b sent%0d exp=0/0/1", ndone_a, busy_a, sent_a);
    end
    clear_mon();
    pulse_start(1'b0);
    wait_done(1'b0, "replay");
    check_full_stream("replay");
    checks++;
    if (sent_a !== 2'd2 || alog_a.size() !== 6 || alog_a[0] !== 16'h0100) begin
      failures++; $display("FAIL replay_status got=sent%0d addrs%0d exp=sent2 addrs6 from 0100", sent_a, alog_a.size());
    end
  endtask

  task automatic test_wrap_and_reset();
    bit found = 1'b0;
    clear_mon(); ready_b = 1'b1;
    pulse_start(1'b1);
    wait_done(1'b1, "wrap");
    checks++;
    if (alog_b.size() !== 3 || alog_b[0] !== 16'hFFFE || alog_b[1] !== 16'hFFFF || alog_b[2] !== 16'h0000) begin
      failures++; $display("FAIL wrap_addr got=count%0d exp=FFFE,FFFF,0000", alog_b.size());
    end
    checks++;
    if (xd_b.size() !== 3 || xd_b[0] !== 16'h8AAA || xd_b[2] !== 16'h0CCC || xl_b[2] !== 1'b1 || sent_b !== 1'b1) begin
      failures++; $display("FAIL wrap_stream got=count%0d sent%0d exp=3 words, last on third, sent1", xd_b.size(), sent_b);
    end
    pulse_start(1'b1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid_b && idx_b == 2'd1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || dout_b !== 16'h0BBB || addr_b !== 16'hFFFF) begin
      failures++; $display("FAIL midlist_pre got=found%0b dout%h addr%h exp=found1 dout0BBB addrFFFF", found, dout_b, addr_b);
    end
    #2 reset_b = 1'b0;
    #1;
    checks++;
    if ({busy_b, valid_b, done_b, greset_b, last_b, addr_b, dout_b, sent_b, idx_b} !== '0) begin
      failures++;
      $display("FAIL midlist_reset got=busy%0b valid%0b addr%h dout%h idx%0d exp=all_zero",
               busy_b, valid_b, addr_b, dout_b, idx_b);
    end
    @(posedge clk); #1;
    reset_b = 1'b1;
    repeat (5) @(posedge clk); #1;
    checks++;
    if (busy_b !== 1'b0 || valid_b !== 1'b0 || addr_b !== 16'h0000) begin
      failures++; $display("FAIL no_resume got=busy%0b valid%0b addr%h exp=0/0/0000", busy_b, valid_b, addr_b);
    end
  endtask

  task automatic test_exclusive_outputs();
    checks++;
    if (nover !== 0) begin
      failures++; $display("FAIL exclusive_outputs got=%0d overlapping cycles exp=0", nover);
    end
  endtask

  initial begin
    reset_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    reset_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    mem_a = '{16'h8001, 16'h0002, 16'h0003, 16'h8004, 16'h0005, 16'h0006, 16'h0000, 16'h0000};
    nover = 0;
    clear_mon();
    test_reset();
    test_full_list();
    test_skip();
    test_backpressure();
    test_abort();
    test_wrap_and_reset();
    test_exclusive_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
